// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: per-producer result FIFOs share NUM_WR reg_file write ports round-robin
// and raise matching ROB completions. Define WB_STALL_CNT_EN to add per-producer stall counters.
module wb_port_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_WR    = 2,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned WORD_SIZE = 64,
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned ROB_PTR_W = 6
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          flush_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [NUM_REQ*PREG_W-1:0]     req_preg_in,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data_in,
    input  logic [NUM_REQ*ROB_PTR_W-1:0]  req_rob_ptr_in,
    output logic [NUM_WR-1:0]             wr_en_out,
    output logic [NUM_WR*PREG_W-1:0]      wr_index_out,
    output logic [NUM_WR*WORD_SIZE-1:0]   wr_data_out,
    output logic [NUM_WR-1:0]             cpl_valid_out,
    output logic [NUM_WR*ROB_PTR_W-1:0]   cpl_rob_ptr_out
`ifdef WB_STALL_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]         stall_cnt_out
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned GNT_W = $clog2(NUM_WR + 1);

    logic [PREG_W-1:0]    r_mem_preg [NUM_REQ][BUF_DEPTH];
    logic [WORD_SIZE-1:0] r_mem_data [NUM_REQ][BUF_DEPTH];
    logic [ROB_PTR_W-1:0] r_mem_rob  [NUM_REQ][BUF_DEPTH];
    logic [PTR_W-1:0]     r_head     [NUM_REQ];
    logic [PTR_W-1:0]     r_tail     [NUM_REQ];
    logic [CNT_W-1:0]     r_count    [NUM_REQ];
    logic [NUM_REQ-1:0]   r_ready;
    logic [IDX_W-1:0]     r_rr_ptr;

    logic [NUM_WR-1:0]    r_wr_en;
    logic [PREG_W-1:0]    r_wr_index [NUM_WR];
    logic [WORD_SIZE-1:0] r_wr_data  [NUM_WR];
    logic [ROB_PTR_W-1:0] r_wr_rob   [NUM_WR];

    logic [NUM_REQ-1:0]   w_push;
    logic [NUM_REQ-1:0]   w_pop;
    logic [NUM_REQ-1:0]   w_nonempty;
    logic [CNT_W-1:0]     w_count_nxt [NUM_REQ];
    logic [NUM_WR-1:0]    w_port_vld;
    logic [IDX_W-1:0]     w_port_src [NUM_WR];
    logic [IDX_W-1:0]     w_last;
    logic [IDX_W-1:0]     w_idx;
    logic [SUM_W-1:0]     w_sum;
    logic [GNT_W-1:0]     w_ngrant;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready comes from the registered flag, so a full FIFO refuses a push even when popped this cycle
    always_comb begin
        w_push     = '0;
        w_nonempty = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_push[i]     = req_valid_in[i] & r_ready[i];
            w_nonempty[i] = (r_count[i] != '0);
        end
    end

    // Round-robin scan from r_rr_ptr; the j-th non-empty FIFO found drives port j
    always_comb begin
        w_pop      = '0;
        w_port_vld = '0;
        w_last     = '0;
        w_idx      = '0;
        w_sum      = '0;
        w_ngrant   = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            w_port_src[k] = '0;
        end
        for (int off = 0; off < NUM_REQ; off++) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(off);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (w_nonempty[w_idx] && (w_ngrant < GNT_W'(NUM_WR))) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (w_ngrant == GNT_W'(k)) begin
                        w_port_vld[k] = 1'b1;
                        w_port_src[k] = w_idx;
                    end
                end
                w_pop[w_idx] = 1'b1;
                w_last       = w_idx;
                w_ngrant     = w_ngrant + GNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_count_nxt[i] = r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_push[i]) begin
                r_mem_preg[i][r_tail[i]] <= req_preg_in[i*PREG_W +: PREG_W];
                r_mem_data[i][r_tail[i]] <= req_data_in[i*WORD_SIZE +: WORD_SIZE];
                r_mem_rob[i][r_tail[i]]  <= req_rob_ptr_in[i*ROB_PTR_W +: ROB_PTR_W];
            end
        end
    end

    // FIFO pointers, occupancy, ready flags and round-robin pointer
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_head[i]  <= '0;
                r_tail[i]  <= '0;
                r_count[i] <= '0;
            end
            r_ready  <= '0;
            r_rr_ptr <= '0;
        end else if (flush_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_head[i]  <= '0;
                r_tail[i]  <= '0;
                r_count[i] <= '0;
            end
            r_ready  <= '1;
            r_rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_push[i]) begin
                    r_tail[i] <= ptr_inc(r_tail[i]);
                end
                if (w_pop[i]) begin
                    r_head[i] <= ptr_inc(r_head[i]);
                end
                r_count[i] <= w_count_nxt[i];
                r_ready[i] <= (w_count_nxt[i] < CNT_W'(BUF_DEPTH));
            end
            if (w_ngrant != '0) begin
                r_rr_ptr <= (w_last == IDX_W'(NUM_REQ - 1)) ? '0 : w_last + IDX_W'(1);
            end
        end
    end

    // Registered write ports; payload is only meaningful while r_wr_en is set
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_en <= '0;
            for (int k = 0; k < NUM_WR; k++) begin
                r_wr_index[k] <= '0;
                r_wr_data[k]  <= '0;
                r_wr_rob[k]   <= '0;
            end
        end else if (flush_in) begin
            r_wr_en <= '0;
        end else begin
            r_wr_en <= w_port_vld;
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_port_vld[k]) begin
                    r_wr_index[k] <= r_mem_preg[w_port_src[k]][r_head[w_port_src[k]]];
                    r_wr_data[k]  <= r_mem_data[w_port_src[k]][r_head[w_port_src[k]]];
                    r_wr_rob[k]   <= r_mem_rob[w_port_src[k]][r_head[w_port_src[k]]];
                end
            end
        end
    end

    assign req_ready_out = r_ready;
    assign wr_en_out     = r_wr_en;
    assign cpl_valid_out = r_wr_en;

    always_comb begin
        wr_index_out    = '0;
        wr_data_out     = '0;
        cpl_rob_ptr_out = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_index_out[k*PREG_W +: PREG_W]          = r_wr_index[k];
            wr_data_out[k*WORD_SIZE +: WORD_SIZE]     = r_wr_data[k];
            cpl_rob_ptr_out[k*ROB_PTR_W +: ROB_PTR_W] = r_wr_rob[k];
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [31:0] r_stall_cnt [NUM_REQ];

    // Saturating count of cycles a producer offered a result that was refused; flush leaves it alone
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stall_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_in[i] && !r_ready[i] && (r_stall_cnt[i] != 32'hFFFF_FFFF)) begin
                    r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stall_cnt_out[i*32 +: 32] = r_stall_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed steps with a per-producer scoreboard checked on every writeback.
module tb_wb_port_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned NW = 2;
    localparam int unsigned WS = 64;
    localparam int unsigned PW = 7;
    localparam int unsigned RW = 6;

    typedef struct packed {
        logic [PW-1:0] preg;
        logic [WS-1:0] data;
        logic [RW-1:0] rob;
    } exp_t;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              flush_in;
    logic [NR-1:0]     req_valid_in;
    logic [NR-1:0]     req_ready_out;
    logic [NR*PW-1:0]  req_preg_in;
    logic [NR*WS-1:0]  req_data_in;
    logic [NR*RW-1:0]  req_rob_ptr_in;
    logic [NW-1:0]     wr_en_out;
    logic [NW*PW-1:0]  wr_index_out;
    logic [NW*WS-1:0]  wr_data_out;
    logic [NW-1:0]     cpl_valid_out;
    logic [NW*RW-1:0]  cpl_rob_ptr_out;
`ifdef WB_STALL_CNT_EN
    logic [NR*32-1:0]  stall_cnt_out;
`endif

    exp_t          sb_q [NR][$];
    int            checks;
    int            errors;
    int            wb_cnt [NR];
    int            stall_exp [NR];
    int            seq [NR];
    logic [NR-1:0] acc;
    int            mon_p;
    exp_t          mon_exp;

    wb_port_arbiter dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .flush_in        (flush_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .req_preg_in     (req_preg_in),
        .req_data_in     (req_data_in),
        .req_rob_ptr_in  (req_rob_ptr_in),
        .wr_en_out       (wr_en_out),
        .wr_index_out    (wr_index_out),
        .wr_data_out     (wr_data_out),
        .cpl_valid_out   (cpl_valid_out),
        .cpl_rob_ptr_out (cpl_rob_ptr_out)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt_out   (stall_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t exp_of(input int p);
        return {req_preg_in[p*PW +: PW], req_data_in[p*WS +: WS], req_rob_ptr_in[p*RW +: RW]};
    endfunction

    function automatic int prod(input int k);
        return int'(wr_data_out[k*WS + 56 +: 8]);
    endfunction

    // Producer id lives in data[63:56] so the monitor can route a writeback to its queue
    task automatic set_req(input int p, input int s, input logic v);
        req_valid_in[p]           = v;
        req_preg_in[p*PW +: PW]   = PW'(p * 20 + s % 20);
        req_data_in[p*WS +: WS]   = {8'(p), 24'hABCDEF, 32'(s)};
        req_rob_ptr_in[p*RW +: RW] = RW'(p * 16 + s % 16);
    endtask

    task automatic clear_sb();
        for (int p = 0; p < NR; p++) sb_q[p].delete();
    endtask

    task automatic step();
        @(negedge clk_in);
        for (int p = 0; p < NR; p++) begin
            acc[p] = req_valid_in[p] && req_ready_out[p] && !flush_in && !rst_in;
            if (acc[p]) sb_q[p].push_back(exp_of(p));
            if (req_valid_in[p] && !req_ready_out[p] && !rst_in) stall_exp[p]++;
        end
        @(posedge clk_in);
        #1;
    endtask

    // Every writeback must be the oldest outstanding result of the producer it carries
    always @(negedge clk_in) begin
        if (!rst_in) begin
            for (int k = 0; k < NW; k++) begin
                if (wr_en_out[k]) begin
                    chk($sformatf("cpl_valid_on%0d", k), 128'(cpl_valid_out[k]), 128'(1));
                    mon_p = prod(k);
                    if (mon_p < NR && sb_q[mon_p].size() > 0) begin
                        mon_exp = sb_q[mon_p].pop_front();
                        wb_cnt[mon_p]++;
                        chk($sformatf("wb_entry_p%0d_port%0d", mon_p, k),
                            128'({wr_index_out[k*PW +: PW], wr_data_out[k*WS +: WS],
                                  cpl_rob_ptr_out[k*RW +: RW]}), 128'(mon_exp));
                    end else begin
                        chk($sformatf("unexpected_wb_port%0d", k), 128'(wr_en_out[k]), 128'(0));
                    end
                end else begin
                    chk($sformatf("cpl_valid_off%0d", k), 128'(cpl_valid_out[k]), 128'(0));
                end
            end
            if (wr_en_out == 2'b11) begin
                chk("rob_distinct", 128'(cpl_rob_ptr_out[RW-1:0] == cpl_rob_ptr_out[2*RW-1:RW]), 128'(0));
            end
        end
    end

    initial begin
        int   p0;
        int   p1;
        int   prev_p0;
        logic saw_low;
        rst_in = 1'b1;
        flush_in = 1'b0;
        req_valid_in = '0;
        req_preg_in = '0;
        req_data_in = '0;
        req_rob_ptr_in = '0;
        checks = 0;
        errors = 0;
        acc = '0;
        for (int p = 0; p < NR; p++) begin
            wb_cnt[p] = 0;
            stall_exp[p] = 0;
            seq[p] = 0;
        end

        // Reset and idle
        #7;
        chk("rst_ready", 128'(req_ready_out), 128'(0));
        chk("rst_wr_en", 128'(wr_en_out), 128'(0));
        chk("rst_cpl_valid", 128'(cpl_valid_out), 128'(0));
        #5 rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        chk("idle_ready", 128'(req_ready_out), 128'(4'hF));
        chk("idle_wr_en", 128'(wr_en_out), 128'(0));
`ifdef WB_STALL_CNT_EN
        chk("idle_stall", 128'(stall_cnt_out), 128'(0));
`endif

        // Single ALU result, two-cycle latency onto port 0
        req_valid_in[0] = 1'b1;
        req_preg_in[PW-1:0] = 7'd5;
        req_data_in[WS-1:0] = 64'hDEAD;
        req_rob_ptr_in[RW-1:0] = 6'd3;
        step();
        req_valid_in[0] = 1'b0;
        chk("t2_lat1_wr_en", 128'(wr_en_out), 128'(2'b00));
        step();
        chk("t2_wr_en", 128'(wr_en_out), 128'(2'b01));
        chk("t2_cpl_valid", 128'(cpl_valid_out), 128'(2'b01));
        chk("t2_idx", 128'(wr_index_out[PW-1:0]), 128'(5));
        chk("t2_data", 128'(wr_data_out[WS-1:0]), 128'(64'hDEAD));
        chk("t2_rob", 128'(cpl_rob_ptr_out[RW-1:0]), 128'(3));
        step();
        chk("t2_after", 128'(wr_en_out), 128'(0));

        // Flush to bring rr_ptr back to 0
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        clear_sb();
        chk("fl0_ready", 128'(req_ready_out), 128'(4'hF));

        // All four push together: (0,1) then (2,3)
        for (int p = 0; p < NR; p++) set_req(p, 0, 1'b1);
        step();
        req_valid_in = '0;
        chk("t3_lat", 128'(wr_en_out), 128'(0));
        step();
        chk("t3_a_en", 128'(wr_en_out), 128'(2'b11));
        chk("t3_a_port0", 128'(prod(0)), 128'(0));
        chk("t3_a_port1", 128'(prod(1)), 128'(1));
        step();
        chk("t3_b_en", 128'(wr_en_out), 128'(2'b11));
        chk("t3_b_port0", 128'(prod(0)), 128'(2));
        chk("t3_b_port1", 128'(prod(1)), 128'(3));
        step();
        chk("t3_idle", 128'(wr_en_out), 128'(0));
        // rr_ptr back at 0: producer 0 ranks ahead of producer 3
        set_req(0, 1, 1'b1);
        set_req(3, 1, 1'b1);
        step();
        req_valid_in = '0;
        step();
        chk("t3_rr_port0", 128'(prod(0)), 128'(0));
        chk("t3_rr_port1", 128'(prod(1)), 128'(3));
        step();

        // Saturation: every producer offers a result each cycle
        for (int p = 0; p < NR; p++) begin
            wb_cnt[p] = 0;
            seq[p] = 10;
            set_req(p, seq[p], 1'b1);
        end
        prev_p0 = -1;
        saw_low = 1'b0;
        for (int c = 0; c < 24; c++) begin
            step();
            for (int p = 0; p < NR; p++) begin
                if (acc[p]) begin
                    seq[p]++;
                    set_req(p, seq[p], 1'b1);
                end
            end
            if (!req_ready_out[0]) saw_low = 1'b1;
            if (wr_en_out == 2'b11) begin
                p0 = prod(0);
                p1 = prod(1);
                chk("t4_pair", 128'(p1), 128'((p0 + 1) % NR));
                if (prev_p0 >= 0) chk("t4_rotate", 128'(p0), 128'((prev_p0 + 2) % NR));
                prev_p0 = p0;
            end else begin
                prev_p0 = -1;
            end
        end
        req_valid_in = '0;
        repeat (6) step();
        chk("t4_ready_dropped", 128'(saw_low), 128'(1));
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("t4_drained_p%0d", p), 128'(sb_q[p].size()), 128'(0));
            chk($sformatf("t4_no_starve_p%0d", p), 128'(wb_cnt[p] >= 10), 128'(1));
        end
`ifdef WB_STALL_CNT_EN
        chk("t4_stalls_seen", 128'(stall_exp[0] > 0), 128'(1));
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("t4_stall_cnt_p%0d", p), 128'(stall_cnt_out[p*32 +: 32]), 128'(stall_exp[p]));
        end
`endif

        // Flush with three queued results; rr_ptr is 1 going in
        set_req(0, 50, 1'b1);
        step();
        req_valid_in = '0;
        step();
        chk("t5_pre", 128'(wr_en_out), 128'(2'b01));
        for (int p = 1; p < NR; p++) set_req(p, 60, 1'b1);
        step();
        req_valid_in = '0;
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        clear_sb();
        chk("t5_wr_en", 128'(wr_en_out), 128'(0));
        chk("t5_cpl_valid", 128'(cpl_valid_out), 128'(0));
        chk("t5_ready", 128'(req_ready_out), 128'(4'hF));
        set_req(0, 61, 1'b1);
        set_req(3, 61, 1'b1);
        step();
        req_valid_in = '0;
        chk("t5_lat", 128'(wr_en_out), 128'(0));
        step();
        chk("t5_en", 128'(wr_en_out), 128'(2'b11));
        chk("t5_rr_port0", 128'(prod(0)), 128'(0));
        chk("t5_rr_port1", 128'(prod(1)), 128'(3));
        repeat (3) step();
        chk("t5_quiet", 128'(wr_en_out), 128'(0));

        // Asynchronous reset while both ports are writing
        for (int p = 0; p < NR; p++) set_req(p, 70, 1'b1);
        step();
        req_valid_in = '0;
        step();
        chk("t6_pre", 128'(wr_en_out), 128'(2'b11));
        #2 rst_in = 1'b1;
        #1;
        chk("t6_wr_en", 128'(wr_en_out), 128'(0));
        chk("t6_cpl_valid", 128'(cpl_valid_out), 128'(0));
        chk("t6_ready", 128'(req_ready_out), 128'(0));
        clear_sb();
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        chk("t6_ready_after", 128'(req_ready_out), 128'(4'hF));
`ifdef WB_STALL_CNT_EN
        chk("t6_stall_cleared", 128'(stall_cnt_out), 128'(0));
`endif
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_empty", 128'(wr_en_out), 128'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
